// File: rtl/alu_exec.sv
// Registered ALU stage with a two-entry (main + skid) output buffer and valid/ready on both sides.
// Latency: an op accepted in cycle N is visible on the outputs in cycle N+1 when the buffer was empty.
// Backpressure: in_ready is low only when both entries are held; a stalled consumer never loses an op.
//
// Ports:
//   clk, reset           : single clock; asynchronous active-high reset clears all state
//   in_valid/in_ready    : producer handshake; alu_c selects the operation on a and b
//   out_valid/out_ready  : consumer handshake; result/zero/ovf/illegal belong to the oldest op
module alu_exec #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_c,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             ovf,
    output logic             illegal
);

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_XOR  = 4'b0010;
    localparam logic [3:0] OP_NOR  = 4'b0011;
    localparam logic [3:0] OP_SLT  = 4'b0100;
    localparam logic [3:0] OP_NAND = 4'b0101;
    localparam logic [3:0] OP_ADD  = 4'b1000;
    localparam logic [3:0] OP_SUB  = 4'b1001;

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             zero;
        logic             ovf;
        logic             illegal;
    } entry_t;

    logic [1:0]       state;
    entry_t           main_q;
    entry_t           skid_q;
    entry_t           new_ent;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             push;
    logic             pop;

    // Handshake signals come from the state register only, never from the
    // opposite side's valid/ready, so there is no combinational path through.
    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign sum  = a + b;
    assign diff = a - b;

    always_comb begin
        new_ent = '0;
        unique case (alu_c)
            OP_AND:  new_ent.result = a & b;
            OP_OR:   new_ent.result = a | b;
            OP_XOR:  new_ent.result = a ^ b;
            OP_NOR:  new_ent.result = ~(a | b);
            OP_SLT:  new_ent.result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_NAND: new_ent.result = ~(a & b);
            OP_ADD: begin
                new_ent.result = sum;
                // Same-sign operands whose sum flips sign have wrapped.
                new_ent.ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                new_ent.result = diff;
                new_ent.ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            default: new_ent.illegal = 1'b1;
        endcase
        new_ent.zero = (new_ent.result == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (push) begin
                        main_q <= new_ent;
                        state  <= ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        // Old main leaves as the new op lands: steady 1 op/cycle.
                        main_q <= new_ent;
                    end else if (push) begin
                        skid_q <= new_ent;
                        state  <= FULL;
                    end else if (pop) begin
                        state  <= EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        main_q <= skid_q;
                        state  <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    assign result  = main_q.result;
    assign zero    = main_q.zero;
    assign ovf     = main_q.ovf;
    assign illegal = main_q.illegal;

endmodule

// File: tb/tb_alu_exec.sv
module tb_alu_exec;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    alu_c;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;
    logic          zero;
    logic          ovf;
    logic          illegal;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] r;
        logic        z;
        logic        o;
        logic        i;
    } exp_t;

    exp_t q[$];

    alu_exec #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_c(alu_c), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .ovf(ovf), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: signed values in 64-bit arithmetic, overflow means the true
    // result does not fit in 32 signed bits.
    function automatic exp_t model(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y);
        exp_t   e;
        longint sx, sy, s;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        e.r = 32'h0; e.o = 1'b0; e.i = 1'b0;
        case (c)
            4'd0: e.r = x & y;
            4'd1: e.r = x | y;
            4'd2: e.r = x ^ y;
            4'd3: e.r = ~(x | y);
            4'd4: e.r = (sx < sy) ? 32'd1 : 32'd0;
            4'd5: e.r = ~(x & y);
            4'd8, 4'd9: begin
                s = (c == 4'd8) ? sx + sy : sx - sy;
                e.r = s[31:0];
                e.o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            default: e.i = 1'b1;
        endcase
        e.z = (e.r == 32'h0);
        return e;
    endfunction

    // Cycle-level scoreboard: compare at negedge, then advance the model by
    // what the coming rising edge will do with the inputs now presented.
    always @(negedge clk) begin
        if (reset) begin
            q.delete();
            chk("rst_out_valid", out_valid, 0);
            chk("rst_in_ready", in_ready, 1);
            chk("rst_result", result, 0);
            chk("rst_flags", {zero, ovf, illegal}, 0);
        end else begin
            bit pu, po;
            chk("in_ready", in_ready, q.size() < 2);
            chk("out_valid", out_valid, q.size() != 0);
            if (q.size() != 0) begin
                chk("result", result, q[0].r);
                chk("zero", zero, q[0].z);
                chk("ovf", ovf, q[0].o);
                chk("illegal", illegal, q[0].i);
            end
            pu = in_valid && (q.size() < 2);
            po = out_ready && (q.size() != 0);
            if (po) void'(q.pop_front());
            if (pu) q.push_back(model(alu_c, a, b));
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] c, input logic [31:0] x, input logic [31:0] y);
        in_valid = v; alu_c = c; a = x; b = y;
    endtask

    function automatic logic [31:0] rnd_operand;
        case ($urandom_range(0, 5))
            0: return 32'h7FFFFFFF;
            1: return 32'h80000000;
            2: return 32'hFFFFFFFF;
            3: return 32'h0;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [3:0] rnd_code;
        logic [3:0] codes [8];
        codes = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd8, 4'd9};
        if ($urandom_range(0, 7) == 0) return 4'($urandom_range(0, 15));
        return codes[$urandom_range(0, 7)];
    endfunction

    initial begin
        reset = 1'b1;
        out_ready = 1'b1;
        drive(0, 4'd0, 0, 0);
        repeat (3) tick;
        reset = 1'b0;
        tick;

        // Overflowing add, visible the cycle after accept.
        drive(1, 4'b1000, 32'h7FFFFFFF, 32'h1);
        tick;
        drive(0, 4'd0, 0, 0);
        chk("add_ovf_valid", out_valid, 1);
        chk("add_ovf_result", result, 32'h80000000);
        chk("add_ovf_flags", {zero, ovf, illegal}, 3'b010);
        tick;

        drive(1, 4'b1001, 32'd5, 32'd5);
        tick;
        chk("sub_eq_result", result, 0);
        chk("sub_eq_flags", {zero, ovf, illegal}, 3'b100);
        drive(1, 4'b0100, 32'hFFFFFFFF, 32'd1);
        tick;
        drive(0, 4'd0, 0, 0);
        chk("slt_neg_result", result, 1);
        tick;

        // Stall: two ops fill the buffer, the third waits.
        out_ready = 1'b0;
        drive(1, 4'b1000, 32'd1, 32'd1);
        tick;
        drive(1, 4'b0001, 32'd2, 32'd4);
        tick;
        drive(1, 4'b0010, 32'd3, 32'd3);
        chk("full_in_ready", in_ready, 0);
        tick;
        chk("full_hold_result", result, 2);
        chk("full_still_blocked", in_ready, 0);
        out_ready = 1'b1;
        tick;
        chk("drain_second", result, 6);
        chk("drain_ready_back", in_ready, 1);
        tick;
        chk("drain_third", result, 0);
        chk("drain_third_zero", zero, 1);
        drive(0, 4'd0, 0, 0);
        tick;
        chk("drain_empty", out_valid, 0);

        // Streaming: one op per cycle with no bubbles.
        for (int i = 0; i < 8; i++) begin
            drive(1, rnd_code(), rnd_operand(), rnd_operand());
            chk("stream_in_ready", in_ready, 1);
            tick;
            chk("stream_out_valid", out_valid, 1);
        end
        drive(0, 4'd0, 0, 0);
        tick;
        chk("stream_done", out_valid, 0);

        // Undefined code still flows as a zero result.
        drive(1, 4'b0110, 32'hFF, 32'h0F);
        tick;
        drive(0, 4'd0, 0, 0);
        chk("illegal_result", result, 0);
        chk("illegal_flags", {zero, ovf, illegal}, 3'b101);
        tick;

        // Asynchronous reset while full discards everything.
        out_ready = 1'b0;
        drive(1, 4'b1000, 32'd7, 32'd8);
        tick;
        drive(1, 4'b0001, 32'd9, 32'd6);
        tick;
        drive(0, 4'd0, 0, 0);
        chk("pre_rst_full", in_ready, 0);
        #2;
        reset = 1'b1;
        #1;
        chk("async_out_valid", out_valid, 0);
        chk("async_in_ready", in_ready, 1);
        chk("async_result", result, 0);
        tick;
        reset = 1'b0;
        out_ready = 1'b1;
        drive(1, 4'b1000, 32'd10, 32'd20);
        tick;
        drive(0, 4'd0, 0, 0);
        chk("post_rst_result", result, 30);
        chk("post_rst_valid", out_valid, 1);
        tick;
        chk("post_rst_no_stale", out_valid, 0);

        // Randomized traffic; producer holds an offer until it is taken.
        begin
            logic rdy_prev;
            rdy_prev = 1'b1;
            for (int i = 0; i < 3000; i++) begin
                if (!(in_valid && !rdy_prev))
                    drive($urandom_range(0, 3) != 0, rnd_code(), rnd_operand(), rnd_operand());
                out_ready = ($urandom_range(0, 3) != 0);
                rdy_prev = in_ready;
                tick;
            end
        end
        drive(0, 4'd0, 0, 0);
        out_ready = 1'b1;
        repeat (4) tick;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
